// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds one uart_send transmitter from N_REQ byte sources.
// The transmitter has no busy flag, so this block times each frame plus the guard gap itself.
module uart_tx_arbiter #(
    parameter int N_REQ      = 4,
    parameter int BAUD_DIV   = 10416,
    parameter int FRAME_BITS = 10,
    parameter int GAP_BITS   = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [8*N_REQ-1:0]         req_data,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       tx_valid,
    output logic [7:0]                 tx_data,
    output logic                       busy,
    output logic [$clog2(N_REQ)-1:0]   grant_id
);

    localparam int          GW = $clog2(N_REQ);
    localparam logic [31:0] W  = 32'((FRAME_BITS + GAP_BITS) * BAUD_DIV);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } state_t;

    state_t            state, state_nx;
    logic [31:0]       cnt, cnt_nx;
    logic [N_REQ-1:0]  ready_nx;
    logic              tx_valid_nx;
    logic [7:0]        data_nx;
    logic              busy_nx;
    logic [GW-1:0]     grant_nx;

    logic              hit;
    logic [GW-1:0]     pick;

    // Search starts one past the last grant; GW-bit addition wraps modulo N_REQ.
    always_comb begin
        hit  = 1'b0;
        pick = grant_id;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!hit && req_valid[grant_id + GW'(k)]) begin
                hit  = 1'b1;
                pick = grant_id + GW'(k);
            end
        end
    end

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        ready_nx    = '0;
        tx_valid_nx = 1'b0;
        data_nx     = tx_data;
        busy_nx     = busy;
        grant_nx    = grant_id;
        case (state)
            IDLE: begin
                busy_nx = 1'b0;
                if (hit) begin
                    data_nx        = req_data[{pick, 3'b000} +: 8];
                    grant_nx       = pick;
                    ready_nx[pick] = 1'b1;
                    tx_valid_nx    = 1'b1;
                    busy_nx        = 1'b1;
                    state_nx       = LAUNCH;
                end
            end
            LAUNCH: begin
                cnt_nx   = W - 32'd1;
                busy_nx  = 1'b1;
                state_nx = WAIT;
            end
            WAIT: begin
                busy_nx = 1'b1;
                if (cnt == 32'd0) begin
                    busy_nx  = 1'b0;
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt - 32'd1;
                end
            end
            default: begin
                busy_nx  = 1'b0;
                state_nx = IDLE;
            end
        endcase
    end

    // Every output is a flop loaded from the next-state logic above.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            req_ready <= '0;
            tx_valid  <= 1'b0;
            tx_data   <= '0;
            busy      <= 1'b0;
            grant_id  <= GW'(N_REQ - 1);
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            req_ready <= ready_nx;
            tx_valid  <= tx_valid_nx;
            tx_data   <= data_nx;
            busy      <= busy_nx;
            grant_id  <= grant_nx;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus random traffic, checked every cycle
// against a launch-time model (next launch allowed W+2 edges after the previous one).
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int BD = 4;
    localparam int W  = (10 + 1) * BD;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [8*N-1:0]  req_data = '0;
    logic [N-1:0]    req_ready;
    logic            tx_valid;
    logic [7:0]      tx_data;
    logic            busy;
    logic [1:0]      grant_id;

    int checks   = 0;
    int failures = 0;

    uart_tx_arbiter #(.N_REQ(N), .BAUD_DIV(BD), .FRAME_BITS(10), .GAP_BITS(1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_valid(tx_valid), .tx_data(tx_data),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] exp_q[$];
    longint     cyc = 0;
    longint     m_last = -1000;
    int         m_grant = N - 1;
    bit         model_on = 0;
    logic       exp_tx_valid = 0;
    logic [N-1:0] exp_ready = '0;
    logic       exp_busy = 0;
    logic [7:0] exp_data = '0;
    logic [1:0] exp_grant = 2'(N - 1);

    always @(posedge clk) begin : model
        int pick;
        bit found;
        cyc <= cyc + 1;
        if (rst) begin
            model_on     <= 1'b1;
            m_grant      <= N - 1;
            m_last       <= -1000;
            exp_tx_valid <= 1'b0;
            exp_ready    <= '0;
            exp_busy     <= 1'b0;
            exp_data     <= '0;
            exp_grant    <= 2'(N - 1);
            exp_q.delete();
        end else begin
            found = 0;
            pick  = m_grant;
            if (cyc >= m_last + W + 2) begin
                for (int k = 1; k <= N; k++) begin
                    if (!found && req_valid[(m_grant + k) % N]) begin
                        found = 1;
                        pick  = (m_grant + k) % N;
                    end
                end
            end
            if (found) begin
                m_grant      <= pick;
                m_last       <= cyc;
                exp_data     <= req_data[8*pick +: 8];
                exp_q.push_back(req_data[8*pick +: 8]);
                exp_tx_valid <= 1'b1;
                exp_ready    <= N'(1) << pick;
                exp_busy     <= 1'b1;
                exp_grant    <= 2'(pick);
            end else begin
                exp_tx_valid <= 1'b0;
                exp_ready    <= '0;
                exp_busy     <= (cyc <= m_last + W);
            end
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            check("tx_valid", tx_valid, exp_tx_valid);
            check("req_ready", req_ready, exp_ready);
            check("busy", busy, exp_busy);
            check("grant_id", grant_id, exp_grant);
            check("tx_data", tx_data, exp_data);
            if (tx_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected_launch got=%0h want=none", tx_data);
                end else begin
                    check("sb_data", tx_data, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic wait_launch(input string name, output int n);
        n = 0;
        while (tx_valid !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (tx_valid !== 1'b1) check({name, "_timeout"}, 0, 1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
        if (busy !== 1'b0) check({name, "_timeout"}, 1, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin : stim
        int n;
        longint t_prev;
        longint t_now;
        logic [7:0] seq_exp[5];
        int spurious;
        int to2;

        // reset values
        do_reset();
        check("rst_busy", busy, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_grant", grant_id, 3);
        check("rst_ready", req_ready, 0);
        check("rst_tx_data", tx_data, 0);

        // 1: single request, latency and busy length
        req_data[7:0] = 8'hA5;
        req_valid     = 4'b0001;
        wait_launch("t1_launch", n);
        check("t1_latency", n, 1);
        check("t1_data", tx_data, 8'hA5);
        check("t1_ready", req_ready, 4'b0001);
        check("t1_grant", grant_id, 0);
        req_valid = '0;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("t1_busy_len", n, 45);

        // 2: all valid, rotation and spacing
        do_reset();
        req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        req_valid = 4'b1111;
        seq_exp   = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
        t_prev    = 0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            wait_launch("t2_launch", n);
            t_now = cyc;
            check("t2_data", tx_data, seq_exp[i]);
            check("t2_ready", req_ready, 4'b0001 << (i % 4));
            if (i > 0) check("t2_spacing", 32'(t_now - t_prev), 46);
            t_prev = t_now;
        end
        req_valid = '0;
        wait_idle("t2_idle");

        // 3: after grant 1, 3 wins over 0
        do_reset();
        req_data[15:8] = 8'h21;
        req_valid      = 4'b0010;
        wait_launch("t3_a", n);
        check("t3_grant1", grant_id, 1);
        req_valid = '0;
        wait_idle("t3_idle");
        req_data[31:24] = 8'h33;
        req_data[7:0]   = 8'h30;
        req_valid       = 4'b1001;
        wait_launch("t3_b", n);
        check("t3_ready3", req_ready, 4'b1000);
        check("t3_data3", tx_data, 8'h33);
        req_valid[3] = 1'b0;
        tick();
        wait_launch("t3_c", n);
        check("t3_ready0", req_ready, 4'b0001);
        check("t3_data0", tx_data, 8'h30);
        req_valid[0] = 1'b0;

        // 4: request raised during WAIT waits, data taken at decision edge
        for (int i = 0; i < 5; i++) tick();
        req_valid[2]     = 1'b1;
        req_data[23:16]  = 8'h55;
        for (int i = 0; i < 3; i++) tick();
        req_data[23:16]  = 8'h66;
        spurious = 0;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            if (tx_valid === 1'b1) spurious++;
            tick();
            n++;
        end
        check("t4_no_launch_in_wait", spurious, 0);
        req_data[23:16] = 8'h77;
        tick();
        check("t4_launch", tx_valid, 1);
        check("t4_ready", req_ready, 4'b0100);
        check("t4_data", tx_data, 8'h77);
        req_valid[2] = 1'b0;

        // 5: reset mid-WAIT with requests held
        req_data[7:0] = 8'h88;
        req_valid     = 4'b0001;
        for (int i = 0; i < 11; i++) tick();
        check("t5_in_wait", busy, 1);
        req_data[15:8]  = 8'h91;
        req_data[23:16] = 8'h92;
        req_valid       = 4'b0110;
        rst = 1'b1;
        tick();
        check("t5_busy", busy, 0);
        check("t5_tx_valid", tx_valid, 0);
        check("t5_grant", grant_id, 3);
        rst = 1'b0;
        tick();
        check("t5_launch", tx_valid, 1);
        check("t5_ready", req_ready, 4'b0010);
        check("t5_data", tx_data, 8'h91);
        req_valid[1] = 1'b0;

        // 6: requester 2 drops before its turn, 3 is served instead
        req_data[31:24] = 8'hA3;
        req_valid[3]    = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        req_valid[2] = 1'b0;
        to2 = 0;
        n = 0;
        while (tx_valid !== 1'b1 && n < 200) begin
            tick();
            n++;
            if (req_ready[2] === 1'b1) to2++;
        end
        check("t6_launch", tx_valid, 1);
        check("t6_ready", req_ready, 4'b1000);
        check("t6_data", tx_data, 8'hA3);
        check("t6_no_ready2", to2, 0);
        req_valid[3] = 1'b0;
        wait_idle("t6_idle");

        // random traffic: hold until ready, occasional abandon, rare reset
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            tick();
            rst = ($urandom_range(0, 1499) == 0);
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    req_valid[i] = 1'b0;
                end else if (!req_valid[i] && $urandom_range(0, 7) == 0) begin
                    req_data[8*i +: 8] = 8'($urandom_range(0, 255));
                    req_valid[i]       = 1'b1;
                end else if (req_valid[i] && $urandom_range(0, 199) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
        end
        rst       = 1'b0;
        req_valid = '0;
        for (int i = 0; i < 60; i++) tick();
        check("sb_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
